// File: rtl/sub_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_adder_pkg
// Description : Shared width, mode encodings and word type for the 16-bit
//               registered adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_adder_pkg;

    localparam int unsigned SA_WIDTH = 16;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef logic [SA_WIDTH-1:0] sa_word_t;

endpackage : sub_adder_pkg
`default_nettype wire

// File: rtl/full_adder_1b.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_1b
// Description : Single-bit full adder, one stage of the ripple carry chain.
// Ports       : a, b, cin -> s (sum bit), cout (carry to next stage)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_prop;

    assign w_prop = a ^ b;
    assign s      = w_prop ^ cin;
    assign cout   = (a & b) | (cin & w_prop);

endmodule : full_adder_1b
`default_nettype wire

// File: rtl/sub_adder_16bit.sv
`default_nettype none
// ============================================================================
// Module      : sub_adder_16bit
// Description : Registered 16-bit two's-complement adder/subtractor.
//               mode = 0 : {cout, sum} <= a + b
//               mode = 1 : {cout, sum} <= a + ~b + 1  (cout = 1 -> no borrow)
//               One-cycle latency, one operation per cycle, no enable.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               a, b  - 16-bit operands
//               mode  - 0 add, 1 subtract
//               sum   - registered result [15:0]
//               cout  - registered carry out of bit 15
//               ovf   - registered signed overflow (SUB_ADDER_OVF_EN only)
// Config      : `define SUB_ADDER_OVF_EN adds the ovf port and register.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_adder_16bit
    import sub_adder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SA_WIDTH-1:0] a,
    input  logic [SA_WIDTH-1:0] b,
    input  logic                mode,
    output logic [SA_WIDTH-1:0] sum,
`ifdef SUB_ADDER_OVF_EN
    output logic                ovf,
`endif
    output logic                cout
);

    // ------------------------------------------------------------------
    // Invert stage: subtraction is a + ~b with the +1 fed in as carry-in.
    // ------------------------------------------------------------------
    sa_word_t            w_b_eff;
    sa_word_t            w_sum;
    logic [SA_WIDTH:0]   w_carry;   // w_carry[i] is the carry into stage i

    assign w_b_eff    = (mode == MODE_SUB) ? ~b : b;
    assign w_carry[0] = (mode == MODE_SUB);

    // ------------------------------------------------------------------
    // Ripple carry chain
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < SA_WIDTH; gi++) begin : g_fa
            full_adder_1b u_fa (
                .a    (a[gi]),
                .b    (w_b_eff[gi]),
                .cin  (w_carry[gi]),
                .s    (w_sum[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    sa_word_t sum_d,  sum_q;
    logic     cout_d, cout_q;

    assign sum_d  = w_sum;
    assign cout_d = w_carry[SA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SUB_ADDER_OVF_EN
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    logic ovf_d, ovf_q;

    assign ovf_d = w_carry[SA_WIDTH-1] ^ w_carry[SA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule : sub_adder_16bit
`default_nettype wire

// File: tb/tb_sub_adder_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_adder_16bit
// Description : Self-checking bench for sub_adder_16bit. Directed cases plus a
//               randomized regression against an arithmetic reference model.
// Config      : honours SUB_ADDER_OVF_EN (checks ovf when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_adder_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [15:0] sum;
    logic        cout;
`ifdef SUB_ADDER_OVF_EN
    logic        ovf;
`endif

    int n_total;
    int n_pass;

    sub_adder_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .mode  (mode),
        .sum   (sum),
`ifdef SUB_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [16:0] model_res(input logic [15:0] ta,
                                              input logic [15:0] tb_,
                                              input logic        tm);
        int unsigned ua, ub, r;
        ua = ta;
        ub = tb_;
        if (!tm) begin
            r = ua + ub;
            return r[16:0];
        end else begin
            r = ua - ub;
            return {(ua >= ub), r[15:0]};
        end
    endfunction

    function automatic logic model_ovf(input logic [15:0] ta,
                                       input logic [15:0] tb_,
                                       input logic        tm);
        int sa, sb, r;
        sa = int'($signed(ta));
        sb = int'($signed(tb_));
        r  = tm ? (sa - sb) : (sa + sb);
        return (r > 32767) || (r < -32768);
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".sum"},  {1'b0, sum},   17'h0);
        chk({tag, ".cout"}, {16'h0, cout}, 17'h0);
`ifdef SUB_ADDER_OVF_EN
        chk({tag, ".ovf"},  {16'h0, ovf},  17'h0);
`endif
    endtask

    // Drive one operation at the falling edge, sample just after the rising edge.
    task automatic op(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                      input string tag);
        logic [16:0] e;
        @(negedge clk);
        a    = ta;
        b    = tb_;
        mode = tm;
        @(posedge clk);
        #1;
        e = model_res(ta, tb_, tm);
        chk({tag, ".sum"},  {1'b0, sum},   {1'b0, e[15:0]});
        chk({tag, ".cout"}, {16'h0, cout}, {16'h0, e[16]});
`ifdef SUB_ADDER_OVF_EN
        chk({tag, ".ovf"},  {16'h0, ovf},  {16'h0, model_ovf(ta, tb_, tm)});
`endif
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // ---------------- Reset held with all-ones operands ----------------
        rst_n = 1'b0;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        mode  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_reset("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // First capture after deassertion: FFFF+FFFF = 1_FFFE
        @(posedge clk);
        #1;
        chk("first_capture", {cout, sum}, 17'h1FFFE);

        // ---------------- Directed add ----------------
        op(16'h1234, 16'h4321, 1'b0, "add_5555");
        chk("add_5555.lit", {cout, sum}, 17'h05555);
        op(16'hFFFF, 16'h0001, 1'b0, "add_wrap");
        chk("add_wrap.lit", {cout, sum}, 17'h10000);

        // ---------------- Directed subtract ----------------
        op(16'h0005, 16'h0003, 1'b1, "sub_pos");
        chk("sub_pos.lit", {cout, sum}, 17'h10002);
        op(16'h0003, 16'h0005, 1'b1, "sub_borrow");
        chk("sub_borrow.lit", {cout, sum}, 17'h0FFFE);
        op(16'h0000, 16'h0000, 1'b1, "sub_zero");
        chk("sub_zero.lit", {cout, sum}, 17'h10000);

        // ---------------- Overflow boundaries ----------------
        op(16'h7FFF, 16'h0001, 1'b0, "ovf_add");
        chk("ovf_add.lit", {cout, sum}, 17'h08000);
        op(16'h8000, 16'h0001, 1'b1, "ovf_sub");
        chk("ovf_sub.lit", {cout, sum}, 17'h17FFF);
`ifdef SUB_ADDER_OVF_EN
        chk("ovf_sub.ovf_lit", {16'h0, ovf}, 17'h1);
`endif
        op(16'h0001, 16'h0001, 1'b0, "no_ovf");
`ifdef SUB_ADDER_OVF_EN
        chk("no_ovf.ovf_lit", {16'h0, ovf}, 17'h0);
`endif

        // ---------------- Inputs changing between edges are ignored ----------------
        op(16'h1111, 16'h2222, 1'b0, "hold_base");
        a    = 16'hABCD;
        b    = 16'h0F0F;
        mode = 1'b1;
        #2;
        chk("hold_between_edges", {cout, sum}, 17'h03333);

        // ---------------- Asynchronous reset mid-stream ----------------
        op(16'hF0F0, 16'h0F0F, 1'b0, "pre_reset");
        #2;                 // well away from any clock edge
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        @(posedge clk);
        #1;
        chk_reset("async_reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        op(16'h0100, 16'h0001, 1'b1, "post_reset");

        // ---------------- Random regression, alternating mode ----------------
        for (int i = 0; i < 10000; i++) begin
            op(16'($urandom), 16'($urandom), 1'(i % 2), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog: keeps the run bounded even if the clock stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_sub_adder_16bit
`default_nettype wire
